// File: rtl/e_mdu_if.sv
// e_mdu_if: E-stage operand/opcode bundle into the MDU and its status/HI/LO outputs.
// The master side is the pipeline (or a bench); the slave side is e_mdu.
interface e_mdu_if;
  logic        req;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic [3:0]  E_MDUOp;
  logic        E_Start;
  logic        E_Busy;
  logic [31:0] E_HILO_Read;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output req, E_A, E_B, E_MDUOp,
    input  E_Start, E_Busy, E_HILO_Read, HI, LO
  );

  modport slave (
    input  req, E_A, E_B, E_MDUOp,
    output E_Start, E_Busy, E_HILO_Read, HI, LO
  );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with architectural HI/LO.
// Results are computed at launch, parked in pHI/pLO, and committed after a
// fixed busy period so HI/LO keep their old values while the op is in flight.
// Optional feature: define MDU_MADD_EN to enable madd/maddu (ops 9 and 10).
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave mdu
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd9;
  localparam logic [3:0] OpMaddu = 4'd10;
`endif

  localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_phi;
  logic [31:0] r_plo;
  logic [3:0]  r_cnt;

  logic [3:0]  w_op;
  logic        w_busy;
  logic        w_start;
  logic        w_launch;
  logic        w_mt_ok;
  logic        w_mul_signed;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic        w_div_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_b_zero;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [63:0] w_res;
  logic [3:0]  w_cnt_ld;
  logic [31:0] w_read;

  assign w_op     = mdu.E_MDUOp;
  assign w_busy   = (r_cnt != 4'd0);

`ifdef MDU_MADD_EN
  assign w_start      = ((w_op >= OpMult) && (w_op <= OpDivu)) ||
                        (w_op == OpMadd) || (w_op == OpMaddu);
  assign w_mul_signed = (w_op == OpMult) || (w_op == OpMadd);
`else
  assign w_start      = (w_op >= OpMult) && (w_op <= OpDivu);
  assign w_mul_signed = (w_op == OpMult);
`endif

  assign w_launch = w_start && !w_busy && !mdu.req;
  assign w_mt_ok  = !w_busy && !mdu.req;

  // One shared 64-bit multiplier; the low 64 bits of the extended product are
  // the exact signed or unsigned result.
  assign w_a_ext = {(w_mul_signed ? {32{mdu.E_A[31]}} : 32'd0), mdu.E_A};
  assign w_b_ext = {(w_mul_signed ? {32{mdu.E_B[31]}} : 32'd0), mdu.E_B};
  assign w_prod  = w_a_ext * w_b_ext;

  // One shared unsigned divider. Signed divide works on magnitudes and fixes
  // signs afterwards; 0x80000000 / -1 falls out as quotient 0x80000000, rem 0.
  assign w_div_signed = (w_op == OpDiv);
  assign w_a_neg      = w_div_signed && mdu.E_A[31];
  assign w_b_neg      = w_div_signed && mdu.E_B[31];
  assign w_b_zero     = (mdu.E_B == 32'd0);
  assign w_dvd        = w_a_neg ? (~mdu.E_A + 32'd1) : mdu.E_A;
  // Divisor forced to 1 on divide-by-zero only to keep the divider defined;
  // the result is discarded in that case.
  assign w_dvs        = w_b_zero ? 32'd1 : (w_b_neg ? (~mdu.E_B + 32'd1) : mdu.E_B);
  assign w_quo        = w_dvd / w_dvs;
  assign w_rem        = w_dvd % w_dvs;
  assign w_quo_fix    = (w_a_neg ^ w_b_neg) ? (~w_quo + 32'd1) : w_quo;
  assign w_rem_fix    = w_a_neg ? (~w_rem + 32'd1) : w_rem;

  // Pending result and busy length for the op in E; defaults keep HI/LO as-is.
  always_comb begin
    w_res    = {r_hi, r_lo};
    w_cnt_ld = 4'd0;
    case (w_op)
      OpMult, OpMultu: begin
        w_res    = w_prod;
        w_cnt_ld = MultCnt;
      end
      OpDiv, OpDivu: begin
        if (!w_b_zero) begin
          w_res = {w_rem_fix, w_quo_fix};
        end
        w_cnt_ld = DivCnt;
      end
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu: begin
        w_res    = {r_hi, r_lo} + w_prod;
        w_cnt_ld = MultCnt;
      end
`endif
      default: ;
    endcase
  end

  // mfhi/mflo read port; reads current HI/LO even while busy.
  always_comb begin
    w_read = 32'd0;
    case (w_op)
      OpMfhi:  w_read = r_hi;
      OpMflo:  w_read = r_lo;
      default: ;
    endcase
  end

  // Launch latches the pending result; countdown commits it at cnt==1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
      r_phi <= 32'd0;
      r_plo <= 32'd0;
      r_cnt <= 4'd0;
    end else begin
      if (w_launch) begin
        r_phi <= w_res[63:32];
        r_plo <= w_res[31:0];
        r_cnt <= w_cnt_ld;
      end else if (r_cnt == 4'd1) begin
        r_hi  <= r_phi;
        r_lo  <= r_plo;
        r_cnt <= 4'd0;
      end else if (w_busy) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // mt* only when idle, so it can never collide with a commit.
      if (w_mt_ok && (w_op == OpMthi)) begin
        r_hi <= mdu.E_A;
      end
      if (w_mt_ok && (w_op == OpMtlo)) begin
        r_lo <= mdu.E_A;
      end
    end
  end

  assign mdu.E_Start     = w_start;
  assign mdu.E_Busy      = w_busy;
  assign mdu.E_HILO_Read = w_read;
  assign mdu.HI          = r_hi;
  assign mdu.LO          = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed scoreboard bench for e_mdu. The stimulus process queues the
// expected outputs for every cycle it drives; a monitor checks them mid-cycle.
module tb_e_mdu;

  typedef struct packed {
    logic        s;
    logic        b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd;
  } exp_t;

  logic clk;
  logic reset;

  e_mdu_if mdu ();

  e_mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mdu  (mdu)
  );

  exp_t        exp_q[$];
  string       name_q[$];
  int          n_vec;
  int          n_bad;
  logic [31:0] e_hi;
  logic [31:0] e_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, required finish before 100000");
    $fatal(1, "timeout");
  end

  // Monitor: one queued expectation per cycle, checked on the falling edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_vec++;
        if ({mdu.E_Start, mdu.E_Busy, mdu.HI, mdu.LO, mdu.E_HILO_Read} !== e) begin
          n_bad++;
          $display("FAIL %s: got start=%0b busy=%0b hi=%h lo=%h rd=%h, required start=%0b busy=%0b hi=%h lo=%h rd=%h",
                   nm, mdu.E_Start, mdu.E_Busy, mdu.HI, mdu.LO, mdu.E_HILO_Read,
                   e.s, e.b, e.hi, e.lo, e.rd);
        end
      end
    end
  end

  task automatic push_exp(input logic xs, input logic xb, input logic [31:0] xrd,
                          input string nm);
    exp_q.push_back('{s: xs, b: xb, hi: e_hi, lo: e_lo, rd: xrd});
    name_q.push_back(nm);
  endtask

  // Drive one cycle of E-stage inputs and queue the outputs expected in it.
  task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic rq, input logic xs, input logic xb, input logic [31:0] xrd,
                     input string nm);
    @(posedge clk);
    #1;
    mdu.E_MDUOp = op;
    mdu.E_A     = a;
    mdu.E_B     = b;
    mdu.req     = rq;
    push_exp(xs, xb, xrd, nm);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] nhi, input logic [31:0] nlo,
                        input string nm);
    cyc(op, a, b, 1'b0, 1'b1, 1'b0, 32'd0, {nm, "_launch"});
    for (int i = 0; i < n; i++) cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, {nm, "_busy"});
    e_hi = nhi;
    e_lo = nlo;
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, {nm, "_done"});
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    e_hi        = 32'd0;
    e_lo        = 32'd0;
    reset       = 1'b1;
    mdu.req     = 1'b0;
    mdu.E_A     = 32'd0;
    mdu.E_B     = 32'd0;
    mdu.E_MDUOp = 4'd0;

    @(posedge clk);
    #1;
    push_exp(1'b0, 1'b0, 32'd0, "reset_state");
    @(negedge clk);
    #1;
    reset = 1'b0;

    // mult -7 * 3 = -21
    run_op(4'd1, 32'hFFFF_FFF9, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m7x3");
    cyc(4'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, "mfhi_mult");
    cyc(4'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFEB, "mflo_mult");

    // divu 100/7, then multu 5*6 launched back-to-back in the first idle cycle
    cyc(4'd4, 32'd100, 32'd7, 1'b0, 1'b1, 1'b0, 32'd0, "divu_launch");
    for (int i = 0; i < 10; i++) cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, "divu_busy");
    e_hi = 32'd2;
    e_lo = 32'd14;
    cyc(4'd2, 32'd5, 32'd6, 1'b0, 1'b1, 1'b0, 32'd0, "b2b_multu_launch");
    for (int i = 0; i < 5; i++) cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, "b2b_busy");
    e_hi = 32'd0;
    e_lo = 32'd30;
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "b2b_done");

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2");
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, "div_ovf");
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");

    // mult flushed by req: no launch, HI/LO untouched
    cyc(4'd1, 32'd2, 32'd3, 1'b1, 1'b1, 1'b0, 32'd0, "mult_req");
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "mult_req_idle");

    // in-flight mult survives req, mf reads old value, mtlo while busy ignored
    cyc(4'd1, 32'd2, 32'd3, 1'b0, 1'b1, 1'b0, 32'd0, "m6_launch");
    cyc(4'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0001, "mflo_busy");
    cyc(4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0, "req_busy");
    cyc(4'd8, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, "mtlo_busy");
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, "m6_busy4");
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, "m6_busy5");
    e_hi = 32'd0;
    e_lo = 32'd6;
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "m6_done");

    // mthi then mfhi
    cyc(4'd7, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "mthi_1234");
    e_hi = 32'h0000_1234;
    cyc(4'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0000_1234, "mfhi_1234");

    // divide by zero keeps HI/LO
    cyc(4'd7, 32'h0000_00AA, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "mthi_aa");
    e_hi = 32'h0000_00AA;
    cyc(4'd8, 32'h0000_00BB, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "mtlo_bb");
    e_lo = 32'h0000_00BB;
    run_op(4'd3, 32'd5, 32'd0, 10, 32'h0000_00AA, 32'h0000_00BB, "div_by0");

    // async reset in busy cycle 3 of a mult, no later commit
    cyc(4'd1, 32'd4, 32'd5, 1'b0, 1'b1, 1'b0, 32'd0, "rst_mult_launch");
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, "rst_mult_busy1");
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, "rst_mult_busy2");
    @(posedge clk);
    #1;
    reset = 1'b1;
    e_hi  = 32'd0;
    e_lo  = 32'd0;
    push_exp(1'b0, 1'b0, 32'd0, "rst_async");
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 7; i++) cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "rst_no_commit");

`ifdef MDU_MADD_EN
    cyc(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "mtlo_ff");
    e_lo = 32'hFFFF_FFFF;
    run_op(4'd10, 32'd1, 32'd1, 5, 32'd1, 32'd0, "maddu_1x1");
`else
    cyc(4'd7, 32'h0000_0055, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "mthi_55");
    e_hi = 32'h0000_0055;
    cyc(4'd9, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0, "madd_off");
    cyc(4'd10, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0, "maddu_off");
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "madd_off_idle");
`endif
    cyc(4'd11, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0, "op11_none");
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "final_idle");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the exception-capable five-stage MIPS pipeline. It consumes the E-stage operands and the MDU opcode latched by the D/E pipeline register. It runs mult/multu/div/divu as multi-cycle operations against architectural HI/LO, and serves mfhi/mflo/mthi/mtlo. Busy and start indications go to the hazard unit, which stalls D while an MDU instruction is waiting.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled); must be ≥1
- DIV_CYCLES, 10, busy cycles for div/divu; must be ≥1

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  1  exception/interrupt taken this cycle; the E-stage instruction is flushed
- E_A  in  32  rs operand, already forwarded
- E_B  in  32  rt operand, already forwarded
- E_MDUOp  in  4  opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11–15 none
- E_Start  out  1  combinational; high when E_MDUOp is 1–4, or 9–10 when enabled
- E_Busy  out  1  registered; high while an operation is in flight
- E_HILO_Read  out  32  combinational; HI for op 5, LO for op 6, else 0
- HI  out  32  architectural HI
- LO  out  32  architectural LO

## Operation
- State:
  - HI and LO
  - pending result registers pHI and pLO
  - 4-bit down-counter cnt
- E_Busy = (cnt != 0).
- Launch: when E_Start is high, E_Busy is 0, and req is 0, the operation launches.
  - Result is computed from E_A/E_B and latched into pHI/pLO at the edge.
  - cnt loads MULT_CYCLES or DIV_CYCLES.
- Commit: at the edge where cnt==1, pHI→HI, pLO→LO, and cnt→0.
- HI/LO hold their old values for the whole busy period.
- mult: {HI,LO} = $signed(E_A) × $signed(E_B), 64-bit.
- multu: the same product, unsigned.
- div: LO = quotient truncated toward zero; HI = remainder, carrying the dividend's sign.
  - Special case 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- divu: unsigned quotient and remainder.
- Divide by zero: still busy for DIV_CYCLES; commits with HI and LO unchanged.
- mthi/mtlo: when E_Busy is 0 and req is 0, HI (or LO) ← E_A at the edge, with no busy period.
- Defensive behaviour (the hazard unit normally prevents these cases):
  - Any start or mt* op presented while E_Busy is 1 is ignored.
  - mf* while busy returns the current, old HI/LO.
- req:
  - Suppresses the launch and any mt* write of the instruction in E that cycle.
  - An operation already in flight is NOT cancelled; it completes and commits normally.
- Reset: HI, LO, pHI, pLO, and cnt go to 0, so E_Busy = 0 immediately and asynchronously.
  - Reset mid-operation discards the pending result.

## Timing
- Launch at edge t0: E_Busy is high from after t0 through t0+N, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO show the new values after edge t0+N, when E_Busy falls.
- An mfhi held by the hazard unit issues in the first cycle that E_Busy is low and reads the committed value.
- A new start is accepted in the same cycle that E_Busy is first observed low, i.e. back-to-back operations with no gap cycle.
- mthi/mtlo: visible on HI/LO and E_HILO_Read in the cycle after their edge.
- E_Start and E_HILO_Read are pure combinational; there is no path from req to any output except through registers.
- Reset values of all outputs: 0.

## Configuration
- Macro: MDU_MADD_EN.
- Defined:
  - op 9 (madd): {HI,LO} + signed product.
  - op 10 (maddu): {HI,LO} + unsigned product.
  - Both use the current HI/LO at launch, are latched into pHI/pLO, take MULT_CYCLES, and drive E_Start.
- Undefined: ops 9–10 decode as none; E_Start stays low and there is no state change.

## Test plan
- mult with E_A=0xFFFFFFF9 (−7), E_B=3 → E_Busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; HI/LO read 0 during busy.
- divu 100/7 → after 10 busy cycles LO=14, HI=2. div 0xFFFFFFF9/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- mult presented with req=1 in the same cycle → E_Busy stays 0 and HI/LO are unchanged. A mult launched earlier followed by req at busy cycle 2 → still commits at cycle 5.
- mthi E_A=0x1234 → HI=0x1234 next cycle; mfhi then gives E_HILO_Read=0x1234. mtlo presented while busy → LO is unchanged by it.
- div by zero with HI=0xAA, LO=0xBB → busy 10 cycles, HI/LO stay 0xAA/0xBB. Assert reset at busy cycle 3 of a mult → E_Busy=0, HI=LO=0 asynchronously, no later commit.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu 1×1 → HI=1, LO=0 after 5 cycles. Without it: op 9 leaves E_Start low and HI/LO unchanged.
